clk_div_ctrl: RTL and testbench

//  Run-time ratio controller in front of the programmable even clock divider.

---
 rtl/clk_div_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time ratio controller for the programmable even clock divider
//
// Takes software ratio-change requests over a req/ack handshake, validates the
// requested ratio, waits for the downstream divider to reach its period
// boundary (wrap_i), then masks the divided clock while div_o changes and
// releases it afterwards, so the divided clock never glitches.
//
// Optional feature macro: CLK_DIV_CTRL_TIMEOUT_EN
//   When defined, a request that sees no wrap_i within TIMEOUT cycles is
//   aborted with ack_o=1, err_o=1 and div_o/clk_en_o left untouched.
//
// Ports:
//   clk_i     in   1  source clock
//   rst_n_i   in   1  asynchronous reset, active low
//   req_i     in   1  change request (level, held until ack_o)
//   div_i     in   7  requested ratio, stable while req_i is high
//   wrap_i    in   1  divider at last count of its period (1-cycle pulse)
//   div_o     out  7  ratio applied to the divider
//   clk_en_o  out  1  divided-clock output enable (0 = output forced low)
//   busy_o    out  1  request in progress
//   ack_o     out  1  1-cycle completion pulse
//   err_o     out  1  1-cycle error flag, valid only with ack_o

module clk_div_ctrl #(
    parameter int DIV_RST  = 8,
    parameter int DIV_MAX  = 126,
    parameter int GATE_CYC = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_i,
    input  logic [6:0] div_i,
    input  logic       wrap_i,
    output logic [6:0] div_o,
    output logic       clk_en_o,
    output logic       busy_o,
    output logic       ack_o,
    output logic       err_o
);

    localparam int         GW        = $clog2(GATE_CYC + 1);
    localparam logic [6:0] DIV_RST_V = 7'(DIV_RST);
    localparam logic [6:0] DIV_MAX_V = 7'(DIV_MAX);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYC - 1);

    // Elaboration-time guard against an illegal parameter set.
    generate
        if ((DIV_RST % 2) != 0 || DIV_RST < 2 || DIV_RST > DIV_MAX ||
            (DIV_MAX % 2) != 0 || DIV_MAX > 126 || GATE_CYC < 1 || TIMEOUT < 1) begin : g_bad_cfg
            $error("clk_div_ctrl: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WRAP = 2'd1,
        S_GATE      = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      div_q, div_d;
    logic [6:0]      lat_q, lat_d;
    logic            clk_en_q, clk_en_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            ack_prev_q;
    logic [GW-1:0]   gate_cnt_q, gate_cnt_d;

    logic            req_ok;
    logic            div_bad;
    logic            div_same;
    logic            gate_end;
    logic            tmo_expire;

    // The master only sees ack_o one cycle late, so req_i is still high in
    // the ack cycle and possibly the one after; neither may start a new request.
    assign req_ok   = req_i && !ack_q && !ack_prev_q;
    assign div_bad  = div_i[0] || (div_i < 7'd2) || (div_i > DIV_MAX_V);
    assign div_same = (div_i == div_q);
    assign gate_end = (gate_cnt_q == GATE_LAST);

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Expiry is the TIMEOUT-th cycle spent in WAIT_WRAP; a wrap_i on that
    // same cycle takes priority in the next-state logic.
    assign tmo_expire = (state_q == S_WAIT_WRAP) && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_WAIT_WRAP && !wrap_i) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_expire = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            div_q      <= DIV_RST_V;
            lat_q      <= DIV_RST_V;
            clk_en_q   <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            lat_q      <= lat_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            ack_prev_q <= ack_q;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_ok && !div_bad && !div_same) begin
                    state_d = S_WAIT_WRAP;
                end
            end
            S_WAIT_WRAP: begin
                if (wrap_i) begin
                    state_d = S_GATE;
                end else if (tmo_expire) begin
                    state_d = S_DONE;
                end
            end
            S_GATE: begin
                if (gate_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, counters and latched ratio.
    always_comb begin
        div_d      = div_q;
        lat_d      = lat_q;
        gate_cnt_d = '0;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        // Enable drops and the new ratio lands on the same edge, so the
        // divider never runs an unmasked period with a half-applied ratio.
        clk_en_d = (state_d != S_GATE);
        busy_d   = (state_d == S_WAIT_WRAP) || (state_d == S_GATE);

        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    if (div_bad) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else if (div_same) begin
                        ack_d = 1'b1;
                    end else begin
                        lat_d = div_i;
                    end
                end
            end
            S_WAIT_WRAP: begin
                if (wrap_i) begin
                    div_d = lat_q;
                end else if (tmo_expire) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end
            end
            S_GATE: begin
                if (gate_end) begin
                    ack_d = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign div_o    = div_q;
    assign clk_en_o = clk_en_q;
    assign busy_o   = busy_q;
    assign ack_o    = ack_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

    localparam int DIV_RST  = 8;
    localparam int DIV_MAX  = 126;
    localparam int GATE_CYC = 4;
    localparam int TIMEOUT  = 16;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [6:0] div_in;
    logic       wrap;
    logic [6:0] div_out;
    logic       clk_en;
    logic       busy;
    logic       ack;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int m_div   = DIV_RST;

    clk_div_ctrl #(
        .DIV_RST (DIV_RST),
        .DIV_MAX (DIV_MAX),
        .GATE_CYC(GATE_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req),
        .div_i   (div_in),
        .wrap_i  (wrap),
        .div_o   (div_out),
        .clk_en_o(clk_en),
        .busy_o  (busy),
        .ack_o   (ack),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int e_div, input int e_en,
                            input int e_busy, input int e_ack, input int e_err);
        chk({tag, " div_o"},    int'(div_out), e_div);
        chk({tag, " clk_en_o"}, int'(clk_en),  e_en);
        chk({tag, " busy_o"},   int'(busy),    e_busy);
        chk({tag, " ack_o"},    int'(ack),     e_ack);
        chk({tag, " err_o"},    int'(err),     e_err);
    endtask

    // One request from the master's point of view. Expected outputs come from
    // the request timeline: request cycle T, wrap pulse at T+wd, gate window of
    // GATE_CYC cycles after the wrap, ack right after the window.
    task automatic do_req(input string name, input int d, input int wd);
        int  ack_k;
        int  old;
        bit  valid;
        bit  same;
        bit  tmo;
        bit  change;
        int  e_div;
        int  e_en;
        int  e_busy;
        int  e_ack;
        int  e_err;
        logic [31:0] dv;

        old   = m_div;
        valid = (d % 2 == 0) && (d >= 2) && (d <= DIV_MAX);
        same  = valid && (d == old);
        tmo   = 1'b0;
        if (!valid || same) begin
            ack_k = 1;
        end else begin
            ack_k = wd + GATE_CYC + 1;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
            if (wd > TIMEOUT) begin
                tmo   = 1'b1;
                ack_k = 1 + TIMEOUT;
            end
`endif
        end
        change = valid && !same && !tmo;

        dv     = d;
        req    = 1'b1;
        div_in = dv[6:0];
        for (int k = 1; k <= ack_k + 3; k++) begin
            @(negedge clk);
            e_ack  = (k == ack_k) ? 1 : 0;
            e_err  = (e_ack == 1 && (!valid || tmo)) ? 1 : 0;
            e_busy = (valid && !same && k < ack_k) ? 1 : 0;
            e_en   = (change && k >= wd + 1 && k <= wd + GATE_CYC) ? 0 : 1;
            e_div  = (change && k >= wd + 1) ? d : old;
            chk_outs($sformatf("%s k=%0d", name, k), e_div, e_en, e_busy, e_ack, e_err);

            wrap = (k == wd) ? 1'b1 : 1'b0;
            if (k == 2 && valid && !same) begin
                div_in = div_in ^ 7'h2a;
            end
            if (k == ack_k + 2) begin
                req = 1'b0;
            end
        end
        wrap = 1'b0;
        if (change) begin
            m_div = d;
        end
    endtask

    initial begin
        int d;
        int wd;
        int cat;

        rst_n  = 1'b0;
        req    = 1'b0;
        div_in = 7'd0;
        wrap   = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs("reset", DIV_RST, 1, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs("post_reset", DIV_RST, 1, 0, 0, 0);

        // wrap_i while idle must not disturb anything
        wrap = 1'b1;
        @(negedge clk);
        wrap = 1'b0;
        @(negedge clk);
        chk_outs("idle_wrap", DIV_RST, 1, 0, 0, 0);

        do_req("invalid_odd", 5, 2);
        do_req("invalid_zero", 0, 2);
        do_req("invalid_127", 127, 2);
        do_req("same_ratio", 8, 2);
        do_req("valid_4", 4, 5);
        do_req("valid_max", DIV_MAX, 1);
        do_req("valid_min", 2, 3);

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        do_req("timeout", 10, TIMEOUT + 4);
        do_req("wrap_at_expiry", 12, TIMEOUT);
`endif

        // reset in the middle of the gate window
        req    = 1'b1;
        div_in = (m_div == 6) ? 7'd10 : 7'd6;
        @(negedge clk);
        wrap = 1'b1;
        @(negedge clk);
        wrap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("gate_before_reset clk_en_o", int'(clk_en), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_reset", DIV_RST, 1, 0, 0, 0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_div = DIV_RST;
        @(negedge clk);
        do_req("after_reset", 20, 2);

        for (int i = 0; i < 24; i++) begin
            cat = $urandom_range(0, 3);
            if (cat == 0) begin
                d = ($urandom_range(0, 1) == 1) ? (2 * $urandom_range(0, 63) + 1) : 0;
            end else if (cat == 1) begin
                d = m_div;
            end else begin
                d = 2 * $urandom_range(1, DIV_MAX / 2);
            end
            wd = $urandom_range(1, 6);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
            if ($urandom_range(0, 4) == 0) begin
                wd = TIMEOUT + 2;
            end
`endif
            wrap = 1'b1;
            @(negedge clk);
            wrap = 1'b0;
            do_req($sformatf("rand%0d", i), d, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
